// File: rtl/nco_phase_gen_if.sv
// FTW load channel for nco_phase_gen: valid/ready transfer of a new frequency tuning word.
// master drives the word, slave (the NCO) accepts it.
interface nco_phase_gen_if #(
    parameter int ACC_W = 16
) ();
    logic [ACC_W-1:0] ftw;
    logic             ftw_valid;
    logic             ftw_ready;

    modport master (
        output ftw,
        output ftw_valid,
        input  ftw_ready
    );

    modport slave (
        input  ftw,
        input  ftw_valid,
        output ftw_ready
    );
endinterface

// File: rtl/nco_phase_gen.sv
// Phase accumulator producing the angle word for a sincos core, with start/stop FSM and
// FTW load handshake. Optional LFSR truncation dither is built when NCO_DITHER_EN is defined.
module nco_phase_gen #(
    parameter int PHASE_W    = 10,
    parameter int ACC_W      = 16,
    parameter int SINCOS_LAT = 4
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               start,
    input  logic               stop,
    nco_phase_gen_if.slave     ftw_bus,
    input  logic [PHASE_W-1:0] poff,
    output logic [PHASE_W-1:0] a,
    output logic               a_valid,
    output logic               wrap,
    output logic               sc_valid,
    output logic               busy
);
    localparam int FRAC_W = ACC_W - PHASE_W;
    localparam int CNT_W  = (SINCOS_LAT > 1) ? $clog2(SINCOS_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_drain_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_acc_carry;
    logic [ACC_W-1:0]   r_ftw_act;
    logic               r_ftw_ready;
    logic [PHASE_W-1:0] r_a;
    logic               r_a_valid;
    logic               r_wrap;
    logic               r_busy;
    logic               r_sc_pipe [SINCOS_LAT];

    logic               w_ftw_fire;
    logic [ACC_W:0]     w_acc_sum;
    logic [PHASE_W-1:0] w_acc_int;
    logic               w_run;
    logic               w_enter_run;

    assign w_run       = (r_state == ST_RUN);
    assign w_enter_run = (r_state == ST_IDLE) && (w_state_next == ST_RUN);
    assign w_ftw_fire  = ftw_bus.ftw_valid && r_ftw_ready;
    assign w_acc_sum   = {1'b0, r_acc} + {1'b0, r_ftw_act};

`ifdef NCO_DITHER_EN
    localparam int DITH_W = (FRAC_W > 16) ? 16 : FRAC_W;

    logic [15:0]      r_lfsr;
    logic             w_lfsr_fb;
    logic [ACC_W-1:0] w_dither;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk) begin
        if (areset) begin
            r_lfsr <= 16'hACE1;
        end else if (w_run) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    generate
        if (DITH_W > 0) begin : g_dither
            assign w_dither = ACC_W'(r_lfsr[DITH_W-1:0]);
        end else begin : g_no_dither
            assign w_dither = '0;
        end
    endgenerate

    // Dither only perturbs the truncation; the accumulator itself never sees it.
    assign w_acc_int = PHASE_W'((r_acc + w_dither) >> FRAC_W);
`else
    assign w_acc_int = r_acc[ACC_W-1 -: PHASE_W];
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == CNT_W'(SINCOS_LAT - 1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
            r_busy      <= 1'b0;
            r_ftw_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + CNT_W'(1) : '0;
            r_busy      <= (w_state_next != ST_IDLE);
            r_ftw_ready <= (w_state_next != ST_DRAIN);
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            r_ftw_act <= '0;
        end else if (w_ftw_fire) begin
            r_ftw_act <= ftw_bus.ftw;
        end
    end

    // r_acc_carry marks an accumulator value produced by an overflowing add, so the wrap
    // pulse lands alongside the first angle computed from the wrapped phase.
    always_ff @(posedge clk) begin
        if (areset) begin
            r_acc       <= '0;
            r_acc_carry <= 1'b0;
        end else if (w_enter_run) begin
            r_acc       <= '0;
            r_acc_carry <= 1'b0;
        end else if (w_run) begin
            r_acc       <= w_acc_sum[ACC_W-1:0];
            r_acc_carry <= w_acc_sum[ACC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            r_a       <= '0;
            r_a_valid <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            if (w_run) begin
                r_a <= w_acc_int + poff;
            end
            r_a_valid <= w_run;
            r_wrap    <= w_run && r_acc_carry;
        end
    end

    generate
        for (genvar gi = 0; gi < SINCOS_LAT; gi++) begin : g_sc_pipe
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (areset) begin
                        r_sc_pipe[gi] <= 1'b0;
                    end else begin
                        r_sc_pipe[gi] <= r_a_valid;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (areset) begin
                        r_sc_pipe[gi] <= 1'b0;
                    end else begin
                        r_sc_pipe[gi] <= r_sc_pipe[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign ftw_bus.ftw_ready = r_ftw_ready;
    assign a                 = r_a;
    assign a_valid           = r_a_valid;
    assign wrap              = r_wrap;
    assign sc_valid          = r_sc_pipe[SINCOS_LAT-1];
    assign busy              = r_busy;
endmodule

// File: tb/tb_nco_phase_gen.sv
// Randomized self-checking bench for nco_phase_gen against a closed-form phase model.
module tb_nco_phase_gen;
    localparam int PW   = 10;
    localparam int AW   = 16;
    localparam int LAT  = 4;
    localparam int FRAC = AW - PW;

    logic          clk = 1'b0;
    logic          areset;
    logic          start;
    logic          stop;
    logic [PW-1:0] poff;
    logic [PW-1:0] a;
    logic          a_valid;
    logic          wrap;
    logic          sc_valid;
    logic          busy;

    nco_phase_gen_if #(.ACC_W(AW)) ftw_bus ();

    nco_phase_gen #(
        .PHASE_W   (PW),
        .ACC_W     (AW),
        .SINCOS_LAT(LAT)
    ) dut (
        .clk     (clk),
        .areset  (areset),
        .start   (start),
        .stop    (stop),
        .ftw_bus (ftw_bus),
        .poff    (poff),
        .a       (a),
        .a_valid (a_valid),
        .wrap    (wrap),
        .sc_valid(sc_valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: phase is the running sum of applied tuning words modulo 2^AW.
    longint unsigned m_ph;
    logic [AW-1:0]   m_ftw;
    bit              m_carry;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] m_a(input logic [PW-1:0] p);
        return PW'((m_ph >> FRAC) + longint'(p));
    endfunction

    function automatic void m_step(input bit load, input logic [AW-1:0] nf);
        longint unsigned nxt;
        nxt     = m_ph + longint'(m_ftw);
        m_carry = (nxt >= (longint'(1) << AW));
        m_ph    = nxt % (longint'(1) << AW);
        if (load) m_ftw = nf;
    endfunction

    function automatic bit a_match(input logic [PW-1:0] act, input logic [PW-1:0] exp);
`ifdef NCO_DITHER_EN
        return (act === exp) || (act === PW'(exp + 1'b1));
`else
        return act === exp;
`endif
    endfunction

    task automatic load_ftw(input logic [AW-1:0] v);
        ftw_bus.ftw       = v;
        ftw_bus.ftw_valid = 1'b1;
        n_cmp++;
        if (ftw_bus.ftw_ready !== 1'b1) begin
            n_err++;
            $display("FAIL load_ready: ftw_ready=%b expected 1", ftw_bus.ftw_ready);
        end
        tick();
        ftw_bus.ftw_valid = 1'b0;
        m_ftw = v;
        $display("xfer ftw=%h", v);
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_ph    = 0;
        m_carry = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || a_valid !== 1'b0) begin
            n_err++;
            $display("FAIL start_latency: busy=%b a_valid=%b expected 1/0", busy, a_valid);
        end
        $display("start poff=%h ftw=%h", poff, m_ftw);
    endtask

    task automatic quiet_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (LAT + 2) tick();
    endtask

    task automatic test_reset();
        areset = 1'b1; start = 1'b0; stop = 1'b0; poff = '0;
        ftw_bus.ftw = '0; ftw_bus.ftw_valid = 1'b0;
        tick(); tick();
        n_cmp++;
        if (a !== '0) begin n_err++; $display("FAIL reset_a: a=%h expected 000", a); end
        n_cmp++;
        if ({a_valid, wrap, sc_valid, busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: av/wr/sc/busy=%b expected 0000", {a_valid, wrap, sc_valid, busy});
        end
        n_cmp++;
        if (ftw_bus.ftw_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready: ftw_ready=%b expected 0", ftw_bus.ftw_ready);
        end
        areset = 1'b0;
        tick();
        n_cmp++;
        if (ftw_bus.ftw_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: ready=%b busy=%b expected 1/0", ftw_bus.ftw_ready, busy);
        end
    endtask

    task automatic test_basic_sweep();
        logic [PW-1:0] ea;
        load_ftw(16'h2000);
        poff = '0;
        start_run();
        for (int k = 0; k < 10; k++) begin
            ea = PW'((k * 'h80) & 'h3FF);
            tick();
            $display("sweep k=%0d a=%h wrap=%b sc=%b", k, a, wrap, sc_valid);
            n_cmp++;
            if (!a_match(a, ea) || a_valid !== 1'b1) begin
                n_err++; $display("FAIL sweep_a k=%0d: a=%h av=%b expected %h/1", k, a, a_valid, ea);
            end
            n_cmp++;
            if (wrap !== (k == 8)) begin
                n_err++; $display("FAIL sweep_wrap k=%0d: wrap=%b expected %b", k, wrap, (k == 8));
            end
            n_cmp++;
            if (sc_valid !== (k >= LAT)) begin
                n_err++; $display("FAIL sweep_sc k=%0d: sc_valid=%b expected %b", k, sc_valid, (k >= LAT));
            end
        end
        quiet_stop();
    endtask

    task automatic test_offset_fraction();
        logic [PW-1:0] tab [6];
        tab = '{10'h3FF, 10'h3FF, 10'h000, 10'h001, 10'h002, 10'h002};
        load_ftw(16'h0030);
        poff = 10'h3FF;
        start_run();
        for (int k = 0; k < 6; k++) begin
            tick();
            $display("offset k=%0d a=%h", k, a);
            n_cmp++;
            if (!a_match(a, tab[k]) || wrap !== 1'b0) begin
                n_err++; $display("FAIL offset k=%0d: a=%h wrap=%b expected %h/0", k, a, wrap, tab[k]);
            end
        end
        quiet_stop();
    endtask

    task automatic test_ftw_change();
        logic [PW-1:0] tab [7];
        bit            ld;
        logic          ew;
        tab = '{10'h000, 10'h080, 10'h100, 10'h180, 10'h200, 10'h300, 10'h000};
        load_ftw(16'h2000);
        poff = '0;
        start_run();
        for (int k = 0; k < 7; k++) begin
            ld = (k == 3);
            ftw_bus.ftw       = 16'h4000;
            ftw_bus.ftw_valid = ld;
            ew = m_carry;
            tick();
            ftw_bus.ftw_valid = 1'b0;
            $display("ftwchg k=%0d a=%h wrap=%b", k, a, wrap);
            n_cmp++;
            if (!a_match(a, tab[k])) begin
                n_err++; $display("FAIL ftwchg_a k=%0d: a=%h expected %h", k, a, tab[k]);
            end
            n_cmp++;
            if (wrap !== ew) begin
                n_err++; $display("FAIL ftwchg_wrap k=%0d: wrap=%b expected %b", k, wrap, ew);
            end
            m_step(ld, 16'h4000);
        end
        quiet_stop();
    endtask

    task automatic test_stop_drain();
        logic [PW-1:0] ea;
        logic [PW-1:0] last_a;
        logic          ew;
        load_ftw(AW'($urandom_range(1, 65535)));
        poff = PW'($urandom);
        start_run();
        for (int k = 0; k < 6; k++) begin
            ea = m_a(poff); ew = m_carry;
            tick();
            n_cmp++;
            if (!a_match(a, ea) || wrap !== ew || sc_valid !== (k >= LAT)) begin
                n_err++;
                $display("FAIL prerun k=%0d: a=%h wrap=%b sc=%b expected %h/%b/%b", k, a, wrap, sc_valid, ea, ew, (k >= LAT));
            end
            m_step(1'b0, '0);
        end
        last_a = m_a(poff);
        for (int j = 0; j < 7; j++) begin
            stop  = (j == 0);
            start = (j == 2);
            ew    = m_carry;
            tick();
            $display("drain j=%0d a=%h av=%b sc=%b busy=%b rdy=%b", j, a, a_valid, sc_valid, busy, ftw_bus.ftw_ready);
            n_cmp++;
            if (!a_match(a, last_a) || a_valid !== (j == 0)) begin
                n_err++; $display("FAIL drain_a j=%0d: a=%h av=%b expected %h/%b", j, a, a_valid, last_a, (j == 0));
            end
            if (j == 0) begin
                n_cmp++;
                if (wrap !== ew) begin
                    n_err++; $display("FAIL drain_wrap: wrap=%b expected %b", wrap, ew);
                end
                last_a = a;
            end
            n_cmp++;
            if (sc_valid !== (j <= LAT)) begin
                n_err++; $display("FAIL drain_sc j=%0d: sc_valid=%b expected %b", j, sc_valid, (j <= LAT));
            end
            n_cmp++;
            if (busy !== (j <= LAT - 1) || ftw_bus.ftw_ready !== (j >= LAT)) begin
                n_err++;
                $display("FAIL drain_busy j=%0d: busy=%b ready=%b expected %b/%b", j, busy, ftw_bus.ftw_ready, (j <= LAT - 1), (j >= LAT));
            end
        end
        stop = 1'b0; start = 1'b0;
    endtask

    task automatic test_start_stop_idle();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        for (int j = 0; j < 3; j++) begin
            $display("startstop j=%0d busy=%b av=%b", j, busy, a_valid);
            n_cmp++;
            if (busy !== 1'b0 || a_valid !== 1'b0 || ftw_bus.ftw_ready !== 1'b1) begin
                n_err++;
                $display("FAIL start_stop_idle j=%0d: busy=%b av=%b ready=%b expected 0/0/1", j, busy, a_valid, ftw_bus.ftw_ready);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [PW-1:0] ea;
        logic          ew;
        bit            ld;
        logic [AW-1:0] nf;
        for (int r = 0; r < 3; r++) begin
            load_ftw(AW'($urandom));
            poff = PW'($urandom);
            start_run();
            for (int k = 0; k < 40; k++) begin
                poff = PW'($urandom);
                ld   = ($urandom_range(0, 3) == 0);
                nf   = AW'($urandom);
                ftw_bus.ftw       = nf;
                ftw_bus.ftw_valid = ld;
                ea = m_a(poff); ew = m_carry;
                tick();
                ftw_bus.ftw_valid = 1'b0;
                $display("rand r=%0d k=%0d a=%h exp=%h wrap=%b", r, k, a, ea, wrap);
                n_cmp++;
                if (!a_match(a, ea) || a_valid !== 1'b1 || wrap !== ew) begin
                    n_err++;
                    $display("FAIL rand r=%0d k=%0d: a=%h av=%b wrap=%b expected %h/1/%b", r, k, a, a_valid, wrap, ea, ew);
                end
                m_step(ld, nf);
            end
            quiet_stop();
        end
    endtask

    task automatic test_reset_mid_run();
        logic [PW-1:0] p;
        load_ftw(AW'($urandom_range(1, 65535)));
        poff = PW'($urandom);
        start_run();
        repeat (5) tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        $display("midreset a=%h av=%b sc=%b busy=%b", a, a_valid, sc_valid, busy);
        n_cmp++;
        if (a !== '0 || {a_valid, sc_valid, busy, wrap} !== 4'b0000 || ftw_bus.ftw_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midreset: a=%h av/sc/busy/wrap=%b ready=%b expected 000/0000/0", a, {a_valid, sc_valid, busy, wrap}, ftw_bus.ftw_ready);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || ftw_bus.ftw_ready !== 1'b1) begin
            n_err++; $display("FAIL midreset_idle: busy=%b ready=%b expected 0/1", busy, ftw_bus.ftw_ready);
        end
        // Reset clears the active FTW, so the phase must stay at the offset.
        p = PW'($urandom);
        poff = p;
        m_ftw = '0;
        start_run();
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (a !== p || a_valid !== 1'b1) begin
                n_err++; $display("FAIL ftw_cleared k=%0d: a=%h av=%b expected %h/1", k, a, a_valid, p);
            end
        end
        quiet_stop();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_sweep();
        test_offset_fraction();
        test_ftw_change();
        test_stop_drain();
        test_start_stop_idle();
        test_random();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
